// File: rtl/sram_dp_arbiter.sv
// sram_dp_arbiter
//   Shares one dual-port, synchronous-read SRAM between NUM_REQ requesters.
//   It grants up to two requests per cycle, one per SRAM port, in round-robin order.
//   A write is never paired with another access to the same address in the same cycle.
//   Read data returns one cycle after the grant, with a per-requester valid pulse.
//   Optional build macro: ARB_CONFLICT_STATS_EN enables the 16-bit saturating
//   count of port-B candidates dropped by the same-address conflict rule.
//   Without the macro, conflict_cnt is tied to zero.
module sram_dp_arbiter #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int DEPTH_LOG = $clog2(DEPTH),
  parameter int NUM_REQ   = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ-1:0]           req_we,
  input  logic [NUM_REQ*DEPTH_LOG-1:0] req_addr,
  input  logic [NUM_REQ*WIDTH-1:0]     req_wdata,
  output logic [NUM_REQ-1:0]           gnt,
  output logic [NUM_REQ-1:0]           rvalid,
  output logic [NUM_REQ*WIDTH-1:0]     rdata,
  output logic                         write_A,
  output logic                         read_A,
  output logic                         write_B,
  output logic                         read_B,
  output logic [DEPTH_LOG-1:0]         addr_A,
  output logic [DEPTH_LOG-1:0]         addr_B,
  output logic [WIDTH-1:0]             data_wr_A,
  output logic [WIDTH-1:0]             data_wr_B,
  input  logic [WIDTH-1:0]             data_rd_A,
  input  logic [WIDTH-1:0]             data_rd_B,
  output logic [15:0]                  conflict_cnt
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Unpacked views of the flattened request buses.
  logic [DEPTH_LOG-1:0] addr_arr  [NUM_REQ];
  logic [WIDTH-1:0]     wdata_arr [NUM_REQ];

  // Round-robin pointer and read-return tags.
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] rvalid_q, rvalid_d;
  logic [NUM_REQ-1:0] rsel_q, rsel_d;     // 1: data comes back on port B

  // Arbitration results.
  logic             a_vld, b_vld, b_gnt, conflict;
  logic [IDX_W-1:0] a_idx, b_idx;
  logic             a_we, b_we;
  logic [DEPTH_LOG-1:0] a_addr, b_addr;
  logic [WIDTH-1:0]     a_wdata, b_wdata;
  logic             rd_a, rd_b;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr[gi*DEPTH_LOG +: DEPTH_LOG];
      assign wdata_arr[gi] = req_wdata[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Scan requesters from rr_ptr (wrapping): first active goes to A, next to B.
  always_comb begin
    int j;
    j     = 0;
    a_vld = 1'b0;
    b_vld = 1'b0;
    a_idx = '0;
    b_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (req[j]) begin
        if (!a_vld) begin
          a_vld = 1'b1;
          a_idx = IDX_W'(j);
        end else if (!b_vld) begin
          b_vld = 1'b1;
          b_idx = IDX_W'(j);
        end
      end
    end
  end

  // Candidate attributes and the same-address conflict rule.
  // Two reads of one address may share the cycle. Any write drops candidate B.
  always_comb begin
    a_we     = req_we[a_idx];
    b_we     = req_we[b_idx];
    a_addr   = addr_arr[a_idx];
    b_addr   = addr_arr[b_idx];
    a_wdata  = wdata_arr[a_idx];
    b_wdata  = wdata_arr[b_idx];
    conflict = a_vld && b_vld && (a_addr == b_addr) && (a_we || b_we);
    b_gnt    = b_vld && !conflict;
    rd_a     = a_vld && !a_we;
    rd_b     = b_gnt && !b_we;
  end

  // Grant vector, forced low while reset is asserted.
  always_comb begin
    gnt = '0;
    if (!reset) begin
      if (a_vld) gnt[a_idx] = 1'b1;
      if (b_gnt) gnt[b_idx] = 1'b1;
    end
  end

  // SRAM port drive; an idle port has strobes, address and data at zero.
  always_comb begin
    write_A   = 1'b0;
    read_A    = 1'b0;
    addr_A    = '0;
    data_wr_A = '0;
    write_B   = 1'b0;
    read_B    = 1'b0;
    addr_B    = '0;
    data_wr_B = '0;
    if (!reset) begin
      if (a_vld) begin
        write_A   = a_we;
        read_A    = !a_we;
        addr_A    = a_addr;
        data_wr_A = a_wdata;
      end
      if (b_gnt) begin
        write_B   = b_we;
        read_B    = !b_we;
        addr_B    = b_addr;
        data_wr_B = b_wdata;
      end
    end
  end

  // Next pointer: one past the last granted index (B if granted, else A).
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (b_gnt) begin
      rr_ptr_d = (b_idx == IDX_W'(NUM_REQ-1)) ? '0 : b_idx + 1'b1;
    end else if (a_vld) begin
      rr_ptr_d = (a_idx == IDX_W'(NUM_REQ-1)) ? '0 : a_idx + 1'b1;
    end
  end

  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_ret
      // Tag each granted read with its requester and port.
      assign rvalid_d[gi] = (rd_a && (a_idx == IDX_W'(gi))) ||
                            (rd_b && (b_idx == IDX_W'(gi)));
      assign rsel_d[gi]   = rd_b && (b_idx == IDX_W'(gi));
      // SRAM output is valid during the cycle after the grant, so steer it directly.
      assign rdata[gi*WIDTH +: WIDTH] = rvalid_q[gi] ? (rsel_q[gi] ? data_rd_B : data_rd_A)
                                                     : '0;
    end
  endgenerate

  assign rvalid = rvalid_q;

  // Pointer and read-return tag registers; async reset discards a pending return.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q <= '0;
      rvalid_q <= '0;
      rsel_q   <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      rvalid_q <= rvalid_d;
      rsel_q   <= rsel_d;
    end
  end

`ifdef ARB_CONFLICT_STATS_EN
  logic [15:0] conflict_cnt_q, conflict_cnt_d;

  // Saturating count of cycles where candidate B was dropped by a conflict.
  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if (conflict && (conflict_cnt_q != 16'hFFFF)) conflict_cnt_d = conflict_cnt_q + 16'd1;
  end

  // Conflict counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) conflict_cnt_q <= '0;
    else       conflict_cnt_q <= conflict_cnt_d;
  end

  assign conflict_cnt = conflict_cnt_q;
`else
  assign conflict_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_sram_dp_arbiter.sv
// Directed testbench for sram_dp_arbiter with a behavioural dual-port SRAM.
module tb_sram_dp_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = '0;
  logic [3:0]  req_we = '0;
  logic [15:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  gnt;
  logic [3:0]  rvalid;
  logic [31:0] rdata;
  logic        write_A, read_A, write_B, read_B;
  logic [3:0]  addr_A, addr_B;
  logic [7:0]  data_wr_A, data_wr_B;
  logic [7:0]  data_rd_A = '0;
  logic [7:0]  data_rd_B = '0;
  logic [15:0] conflict_cnt;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_cnt;

  logic [7:0] mem [0:15] = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6, 8'h11,
                             8'hC8, 8'hC9, 8'hCA, 8'hCB, 8'hCC, 8'hCD, 8'hCE, 8'hCF};

  sram_dp_arbiter #(.WIDTH(8), .DEPTH(16), .NUM_REQ(4)) dut (
    .clk(clk), .reset(reset), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .write_A(write_A), .read_A(read_A), .write_B(write_B), .read_B(read_B),
    .addr_A(addr_A), .addr_B(addr_B), .data_wr_A(data_wr_A), .data_wr_B(data_wr_B),
    .data_rd_A(data_rd_A), .data_rd_B(data_rd_B), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  // Dual-port synchronous-read SRAM model
  always @(posedge clk) begin
    if (write_A) mem[addr_A] <= data_wr_A;
    if (write_B) mem[addr_B] <= data_wr_B;
    if (read_A)  data_rd_A <= mem[addr_A];
    if (read_B)  data_rd_B <= mem[addr_B];
  end

  task automatic set_req(input int i, input logic we, input logic [3:0] a, input logic [7:0] d);
    req[i] = 1'b1;
    req_we[i] = we;
    req_addr[i*4 +: 4] = a;
    req_wdata[i*8 +: 8] = d;
  endtask

  task automatic clear_all();
    req = '0;
    req_we = '0;
    req_addr = '0;
    req_wdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_all();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    $display("test_reset: reset held with traffic, released, re-asserted mid-read");
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 4'(i), 8'h00);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b expected %b", gnt, 4'b0000); end
    checks++; if ({write_A, read_A, write_B, read_B} !== 4'b0000) begin errors++; $display("FAIL reset_strobes: got %b expected 0000", {write_A, read_A, write_B, read_B}); end
    checks++; if (rvalid !== 4'b0000 || rdata !== 32'h0) begin errors++; $display("FAIL reset_rvalid: got %b/%h expected 0000/00000000", rvalid, rdata); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (gnt !== 4'b0011) begin errors++; $display("FAIL release_gnt: got %b expected %b", gnt, 4'b0011); end
    @(posedge clk);
    #1;
    checks++; if (rvalid !== 4'b0011) begin errors++; $display("FAIL pre_reset_rvalid: got %b expected 0011", rvalid); end
    reset = 1'b1;
    #1;
    checks++; if (rvalid !== 4'b0000 || gnt !== 4'b0000) begin errors++; $display("FAIL midreset_discard: rvalid %b gnt %b expected 0000 0000", rvalid, gnt); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({write_A, read_A, write_B, read_B} !== 4'b0000 || rvalid !== 4'b0000) begin errors++; $display("FAIL midreset_strobes: strobes %b rvalid %b expected 0", {write_A, read_A, write_B, read_B}, rvalid); end
    @(negedge clk);
    clear_all();
    reset = 1'b0;
    #1;
    checks++; if (conflict_cnt !== 16'h0) begin errors++; $display("FAIL reset_cnt: got %h expected 0000", conflict_cnt); end
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 4'(i), 8'h00);
    #1;
    checks++; if (gnt !== 4'b0011) begin errors++; $display("FAIL reset_rrptr: got %b expected 0011", gnt); end
    clear_all();
  endtask

  task automatic test_single();
    $display("test_single: req1 write addr 3 = 5A, then two reads");
    do_reset();
    set_req(1, 1'b1, 4'd3, 8'h5A);
    #1;
    checks++; if (gnt !== 4'b0010 || write_A !== 1'b1 || addr_A !== 4'd3 || data_wr_A !== 8'h5A || write_B !== 1'b0)
      begin errors++; $display("FAIL single_write: gnt %b wA %b addrA %h dA %h wB %b expected 0010 1 3 5a 0", gnt, write_A, addr_A, data_wr_A, write_B); end
    @(posedge clk);
    @(negedge clk);
    set_req(1, 1'b0, 4'd3, 8'h00);
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++; if (gnt !== 4'b0010 || read_A !== 1'b1 || read_B !== 1'b0) begin errors++; $display("FAIL single_read_gnt[%0d]: gnt %b rA %b rB %b expected 0010 1 0", c, gnt, read_A, read_B); end
      @(posedge clk);
      #1;
      checks++; if (rvalid !== 4'b0010 || rdata[15:8] !== 8'h5A) begin errors++; $display("FAIL single_rdata[%0d]: rvalid %b data %h expected 0010 5a", c, rvalid, rdata[15:8]); end
      @(negedge clk);
    end
    clear_all();
    @(posedge clk);
    #1;
    checks++; if (rvalid !== 4'b0000) begin errors++; $display("FAIL single_pulse_end: got %b expected 0000", rvalid); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    $display("test_round_robin: four readers of addrs 0..3");
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 4'(i), 8'h00);
    for (int c = 0; c < 6; c++) begin
      exp_g = (c % 2 == 0) ? 4'b0011 : 4'b1100;
      #1;
      checks++; if (gnt !== exp_g) begin errors++; $display("FAIL rr_gnt[%0d]: got %b expected %b", c, gnt, exp_g); end
      @(posedge clk);
      #1;
      checks++; if (rvalid !== exp_g) begin errors++; $display("FAIL rr_rvalid[%0d]: got %b expected %b", c, rvalid, exp_g); end
      for (int i = 0; i < 4; i++) begin
        if (exp_g[i]) begin
          checks++; if (rdata[i*8 +: 8] !== 8'hC0 + 8'(i)) begin errors++; $display("FAIL rr_rdata[%0d][%0d]: got %h expected %h", c, i, rdata[i*8 +: 8], 8'hC0 + 8'(i)); end
        end
      end
      @(negedge clk);
    end
    clear_all();
  endtask

  task automatic test_ww_conflict();
    $display("test_ww_conflict: req0 and req1 write addr 5");
    do_reset();
    set_req(0, 1'b1, 4'd5, 8'hAA);
    set_req(1, 1'b1, 4'd5, 8'hBB);
    #1;
    checks++; if (gnt !== 4'b0001 || data_wr_A !== 8'hAA || write_B !== 1'b0) begin errors++; $display("FAIL ww_cycle1: gnt %b dA %h wB %b expected 0001 aa 0", gnt, data_wr_A, write_B); end
    @(posedge clk);
    @(negedge clk);
    req[0] = 1'b0;
    #1;
    checks++; if (gnt !== 4'b0010 || write_A !== 1'b1 || data_wr_A !== 8'hBB) begin errors++; $display("FAIL ww_cycle2: gnt %b wA %b dA %h expected 0010 1 bb", gnt, write_A, data_wr_A); end
    @(posedge clk);
    @(negedge clk);
    clear_all();
    set_req(2, 1'b0, 4'd5, 8'h00);
    #1;
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL ww_readback_gnt: got %b expected 0100", gnt); end
    @(posedge clk);
    #1;
    checks++; if (rvalid !== 4'b0100 || rdata[23:16] !== 8'hBB) begin errors++; $display("FAIL ww_readback: rvalid %b data %h expected 0100 bb", rvalid, rdata[23:16]); end
`ifdef ARB_CONFLICT_STATS_EN
    exp_cnt = 16'd1;
`else
    exp_cnt = 16'd0;
`endif
    checks++; if (conflict_cnt !== exp_cnt) begin errors++; $display("FAIL ww_cnt: got %h expected %h", conflict_cnt, exp_cnt); end
    @(negedge clk);
    clear_all();
  endtask

  task automatic test_wr_conflict();
    $display("test_wr_conflict: req2 write addr 9 = 3C, req3 read addr 9");
    do_reset();
    set_req(2, 1'b1, 4'd9, 8'h3C);
    set_req(3, 1'b0, 4'd9, 8'h00);
    #1;
    checks++; if (gnt !== 4'b0100 || read_B !== 1'b0 || write_A !== 1'b1) begin errors++; $display("FAIL wr_cycle1: gnt %b rB %b wA %b expected 0100 0 1", gnt, read_B, write_A); end
    @(posedge clk);
    #1;
    checks++; if (rvalid !== 4'b0000) begin errors++; $display("FAIL wr_no_early_rvalid: got %b expected 0000", rvalid); end
    @(negedge clk);
    req[2] = 1'b0;
    #1;
    checks++; if (gnt !== 4'b1000 || read_A !== 1'b1) begin errors++; $display("FAIL wr_cycle2: gnt %b rA %b expected 1000 1", gnt, read_A); end
    @(posedge clk);
    #1;
    checks++; if (rvalid !== 4'b1000 || rdata[31:24] !== 8'h3C) begin errors++; $display("FAIL wr_rdata: rvalid %b data %h expected 1000 3c", rvalid, rdata[31:24]); end
`ifdef ARB_CONFLICT_STATS_EN
    exp_cnt = 16'd1;
`else
    exp_cnt = 16'd0;
`endif
    checks++; if (conflict_cnt !== exp_cnt) begin errors++; $display("FAIL wr_cnt: got %h expected %h", conflict_cnt, exp_cnt); end
    @(negedge clk);
    clear_all();
  endtask

  task automatic test_rr_same();
    $display("test_rr_same: req0 and req1 read addr 7");
    do_reset();
    set_req(0, 1'b0, 4'd7, 8'h00);
    set_req(1, 1'b0, 4'd7, 8'h00);
    #1;
    checks++; if (gnt !== 4'b0011 || read_A !== 1'b1 || read_B !== 1'b1 || addr_B !== 4'd7) begin errors++; $display("FAIL rrs_gnt: gnt %b rA %b rB %b addrB %h expected 0011 1 1 7", gnt, read_A, read_B, addr_B); end
    @(posedge clk);
    #1;
    checks++; if (rvalid !== 4'b0011 || rdata[15:0] !== 16'h1111) begin errors++; $display("FAIL rrs_rdata: rvalid %b data %h expected 0011 1111", rvalid, rdata[15:0]); end
    checks++; if (conflict_cnt !== 16'h0) begin errors++; $display("FAIL rrs_cnt: got %h expected 0000", conflict_cnt); end
    @(negedge clk);
    clear_all();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_ww_conflict();
    test_wr_conflict();
    test_rr_same();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_dp_arbiter.md
Name: sram_dp_arbiter

Overview:
- Shares one dual-port synchronous-read SRAM between NUM_REQ requesters, granting up to two requests per cycle (one per SRAM port).
- Sits between client logic and the SRAM instance. Owns all SRAM strobes, addresses and write data.
- Round-robin fairness; resolves same-address port conflicts; returns read data with a per-requester valid.

Parameters:
- WIDTH, 8, data width in bits.
- DEPTH, 16, SRAM words.
- DEPTH_LOG, $clog2(DEPTH), address width.
- NUM_REQ, 4, number of requesters (2..8).

Ports:
- clk  in  1  single clock, all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  request per requester; held until granted.
- req_we  in  NUM_REQ  1=write, 0=read.
- req_addr  in  NUM_REQ*DEPTH_LOG  flattened addresses, requester i at [i*DEPTH_LOG +: DEPTH_LOG].
- req_wdata  in  NUM_REQ*WIDTH  flattened write data.
- gnt  out  NUM_REQ  combinational grant; request accepted when req[i]&gnt[i] at posedge.
- rvalid  out  NUM_REQ  registered; read data valid for requester i.
- rdata  out  NUM_REQ*WIDTH  flattened read data, valid only with rvalid[i].
- write_A, read_A, write_B, read_B  out  1 each  SRAM port strobes.
- addr_A, addr_B  out  DEPTH_LOG  SRAM addresses.
- data_wr_A, data_wr_B  out  WIDTH  SRAM write data.
- data_rd_A, data_rd_B  in  WIDTH  SRAM read data, updated at the posedge where the read strobe is sampled.
- conflict_cnt  out  16  stall counter (see Optional Feature).

Behaviour:
- Reset (async assert): rr_ptr=0, rvalid=0, rdata=0, tag registers cleared, conflict_cnt=0. gnt and all SRAM strobes forced 0 while reset=1.
- Arbitration, combinational each cycle:
  - Scan requesters starting at rr_ptr, wrapping modulo NUM_REQ.
  - First active requester -> port A candidate. Next active requester -> port B candidate.
- Conflict rules (B candidate dropped, and stays requesting):
  - A and B address equal and either is a write.
  - Two reads to the same address are both granted.
- Port drive:
  - Granted requester's addr and wdata go to the port.
  - write_x=req_we, read_x=~req_we. Unused port: strobes 0, addr/data 0.
- rr_ptr update at posedge: (last granted index + 1) mod NUM_REQ, where last = B if granted else A. No grant -> rr_ptr unchanged.
- Read return, latency 1:
  - Read granted on port P in cycle n -> rvalid[i]=1 in cycle n+1, rdata slice i = data_rd_P.
  - Port/requester tag registered at grant.
  - rvalid is a one-cycle pulse; back-to-back reads give consecutive pulses.
- Writes: no response; gnt is the acknowledgement.
- Single requester active: always granted on port A every cycle it requests.
- No request queueing: requester may change addr/we only after its grant.
- Reset asserted mid-read: pending rvalid is discarded.

Optional Feature:
- Macro ARB_CONFLICT_STATS_EN.
  - Defined: conflict_cnt increments at each posedge where a B candidate was dropped by the conflict rule; saturates at 16'hFFFF; cleared by reset.
  - Undefined: conflict_cnt tied to 0 and no counter logic is synthesized.
- Arbitration behaviour is identical in both builds.

Test Plan:
- Reset mid-traffic: assert reset for 3 cycles -> gnt=0, rvalid=0, all strobes 0, rr_ptr=0, conflict_cnt=0 after release.
- Single requester: req[1]=1, write addr 3 data 8'h5A, then read addr 3 -> gnt[1] each cycle, on port A; rvalid[1]=1 one cycle after read grant with rdata=8'h5A.
- Round-robin: all 4 requesters read distinct addrs 0..3 continuously -> grant pairs (0,1),(2,3),(0,1)...; every requester served within 2 cycles.
- Write/write conflict: req0 write addr 5=8'hAA and req1 write addr 5=8'hBB, rr_ptr=0 -> cycle 1 only gnt[0]; cycle 2 gnt[1]. Final read of addr 5 = 8'hBB. With ARB_CONFLICT_STATS_EN, conflict_cnt=1.
- Write/read same address: req2 write addr 9=8'h3C with req3 read addr 9 -> read deferred one cycle; rvalid[3] returns 8'h3C.
- Read/read same address: req0 and req1 read addr 7 (holding 8'h11) -> both granted same cycle; rvalid[0] and rvalid[1] both 8'h11 next cycle; conflict_cnt unchanged.
